// File: rtl/bus_switch_pkg.sv
// bus_switch_pkg: shared types and defaults for the N-slave bus switch.
// FSM state encoding, error-cause encoding, default widths and slave limits.
package bus_switch_pkg;

    localparam int MAX_SLAVES   = 8;
    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SEL_W    = DEF_DATA_W / 8;
    localparam int DEF_TMO_CYC  = 255;
    localparam int TMO_CNT_W    = 16;

    // Transfer FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        RESP_OK  = 2'd2,
        RESP_ERR = 2'd3
    } state_e;

    // Why a transfer ended in RESP_ERR
    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_ADDR = 2'd1,
        CAUSE_TMO  = 2'd2
    } err_cause_e;

endpackage

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: combinational base/mask address decoder.
// Slave i matches when (adr & mask_i) == base_i; among several matches the
// lowest index wins, so the hit vector is always one-hot or zero.
module bus_addr_decode
    import bus_switch_pkg::*;
#(
    parameter int N_SLAVES = 4,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic [ADDR_W-1:0]          i_adr,
    input  logic [N_SLAVES*ADDR_W-1:0] i_base_addrs,
    input  logic [N_SLAVES*ADDR_W-1:0] i_addr_masks,
    output logic [N_SLAVES-1:0]        o_hit,
    output logic                       o_miss
);

    logic w_found;

    // Priority match: first slave whose masked address equals its base
    always_comb begin
        o_hit   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!w_found &&
                ((i_adr & i_addr_masks[i*ADDR_W +: ADDR_W]) ==
                 i_base_addrs[i*ADDR_W +: ADDR_W])) begin
                o_hit[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        o_miss = !w_found;
    end

endmodule

// File: rtl/bus_switch_n.sv
// bus_switch_n: registered bus switch, one master to N_SLAVES slaves.
// Each transfer: IDLE (latch + decode) -> ACCESS (drive one slave) ->
// RESP_OK / RESP_ERR (one-cycle ack or err pulse) -> IDLE.
// Optional feature macro: BUS_SWITCH_TIMEOUT_EN enables the ACCESS timeout
// counter and tmo_err_o; without it ACCESS waits for an ack indefinitely.
//
// Handshake: the master raises master_stb_i with a stable request and holds
// it until it sees master_ack_o or master_err_o, then drops it the next
// cycle; a strobe still high while IDLE starts a new transfer. Toward the
// slave, cyc/stb stay high on the selected port until that port acks.
module bus_switch_n
    import bus_switch_pkg::*;
#(
    parameter int                          N_SLAVES    = 4,
    parameter int                          ADDR_W      = DEF_ADDR_W,
    parameter int                          DATA_W      = DEF_DATA_W,
    parameter logic [N_SLAVES*ADDR_W-1:0]  BASE_ADDRS  = '0,
    parameter logic [N_SLAVES*ADDR_W-1:0]  ADDR_MASKS  = '0,
    parameter int                          TIMEOUT_CYC = DEF_TMO_CYC,
    localparam int                         SEL_W       = DATA_W / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       master_stb_i,
    input  logic                       master_we_i,
    input  logic [ADDR_W-1:0]          master_adr_i,
    input  logic [DATA_W-1:0]          master_dat_i,
    input  logic [SEL_W-1:0]           master_sel_i,
    output logic [DATA_W-1:0]          master_dat_o,
    output logic                       master_ack_o,
    output logic                       master_err_o,
    output logic                       adr_err_o,
    output logic                       tmo_err_o,
    output logic [N_SLAVES-1:0]        slave_cyc_o,
    output logic [N_SLAVES-1:0]        slave_stb_o,
    output logic                       slave_we_o,
    output logic [ADDR_W-1:0]          slave_adr_o,
    output logic [DATA_W-1:0]          slave_dat_o,
    output logic [SEL_W-1:0]           slave_sel_o,
    input  logic [N_SLAVES*DATA_W-1:0] slave_dat_i,
    input  logic [N_SLAVES-1:0]        slave_ack_i,
    output state_e                     dbg_state_o
);

    state_e               r_state;
    state_e               w_next;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_adr;
    logic [DATA_W-1:0]    r_wdat;
    logic [SEL_W-1:0]     r_sel;
    logic [N_SLAVES-1:0]  r_hit;
    err_cause_e           r_cause;
    logic [DATA_W-1:0]    r_rdat;

    logic [N_SLAVES-1:0]  w_hit;
    logic                 w_miss;
    logic                 w_sel_ack;
    logic [DATA_W-1:0]    w_sel_dat;
    logic                 w_tmo_hit;
    logic                 w_accept;

    bus_addr_decode #(
        .N_SLAVES (N_SLAVES),
        .ADDR_W   (ADDR_W)
    ) u_decode (
        .i_adr        (master_adr_i),
        .i_base_addrs (BASE_ADDRS),
        .i_addr_masks (ADDR_MASKS),
        .o_hit        (w_hit),
        .o_miss       (w_miss)
    );

    assign w_accept  = (r_state == IDLE) && master_stb_i;
    // Only the selected slave's ack counts; others are ignored
    assign w_sel_ack = (r_state == ACCESS) && |(slave_ack_i & r_hit);

    // Read-data mux driven by the latched one-hot select
    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (r_hit[i]) begin
                w_sel_dat = w_sel_dat | slave_dat_i[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef BUS_SWITCH_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYC - 1);

    logic [TMO_CNT_W-1:0] r_tmo_cnt;

    // Counts ACCESS cycles; held at zero everywhere else so it is clear on entry
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ACCESS) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end else begin
            r_tmo_cnt <= '0;
        end
    end

    assign w_tmo_hit = (r_state == ACCESS) && (r_tmo_cnt == TMO_LAST);
`else
    assign w_tmo_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an ack in the terminal-count cycle beats the timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (master_stb_i) begin
                    w_next = w_miss ? RESP_ERR : ACCESS;
                end
            end
            ACCESS: begin
                if (w_sel_ack) begin
                    w_next = RESP_OK;
                end else if (w_tmo_hit) begin
                    w_next = RESP_ERR;
                end
            end
            RESP_OK:  w_next = IDLE;
            RESP_ERR: w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Request latch, select vector and error cause, captured in IDLE
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_sel   <= '0;
            r_hit   <= '0;
            r_cause <= CAUSE_NONE;
        end else if (w_accept) begin
            r_we    <= master_we_i;
            r_adr   <= master_adr_i;
            r_wdat  <= master_dat_i;
            r_sel   <= master_sel_i;
            r_hit   <= w_hit;
            r_cause <= w_miss ? CAUSE_ADDR : CAUSE_NONE;
        end else if (!w_sel_ack && w_tmo_hit) begin
            r_cause <= CAUSE_TMO;
        end
    end

    // Read data captured on the selected ack; zero in every other cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rdat <= '0;
        end else if (w_sel_ack) begin
            r_rdat <= w_sel_dat;
        end else begin
            r_rdat <= '0;
        end
    end

    assign master_dat_o = r_rdat;
    assign master_ack_o = (r_state == RESP_OK);
    assign master_err_o = (r_state == RESP_ERR);
    assign adr_err_o    = (r_state == RESP_ERR) && (r_cause == CAUSE_ADDR);
`ifdef BUS_SWITCH_TIMEOUT_EN
    assign tmo_err_o    = (r_state == RESP_ERR) && (r_cause == CAUSE_TMO);
`else
    assign tmo_err_o    = 1'b0;
`endif

    // Slave strobes come straight from state so reset drops them at once
    assign slave_cyc_o  = (r_state == ACCESS) ? r_hit : '0;
    assign slave_stb_o  = (r_state == ACCESS) ? r_hit : '0;
    assign slave_we_o   = r_we;
    assign slave_adr_o  = r_adr;
    assign slave_dat_o  = r_wdat;
    assign slave_sel_o  = r_sel;
    assign dbg_state_o  = r_state;

endmodule
